// File: rtl/bcd_accum_scan_ctrl.sv
// ============================================================================
// Module   : bcd_accum_scan_ctrl
// Brief    : 4-digit BCD accumulator with a digit-serial adder FSM and a
//            multiplexed display scan (one-hot digit enable + hex code).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_accum_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add_req,
  input  logic [3:0]  operand,
  input  logic [1:0]  op_pos,
  input  logic        clr,
  output logic [15:0] acc,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ovf,
  output logic [3:0]  dig,
  output logic [3:0]  disp_hex
);

  localparam logic [15:0] c_scan_last = SCAN_DIV - 16'd1;
  localparam logic [3:0]  c_err_hex   = 4'hE;
  localparam logic [3:0]  c_bcd_max   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  pos_q, pos_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  scan_idx_q, scan_idx_d;

  logic [3:0]  w_digits [4];
  logic [3:0]  w_cur_digit;
  logic [3:0]  w_addend;
  logic [4:0]  w_sum;
  logic        w_carry_out;
  logic [3:0]  w_digit_res;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign w_digits[gi] = acc_q[4*gi +: 4];
    end
  endgenerate

  // Digit-serial BCD add: 5-bit sum, max 9+9+1 = 19; the 4-bit subtract of 10
  // wraps correctly for sums 16..19 as well.
  assign w_cur_digit = w_digits[idx_q];
  assign w_addend    = (idx_q == pos_q) ? op_q : 4'd0;
  assign w_sum       = {1'b0, w_cur_digit} + {1'b0, w_addend} + {4'd0, carry_q};
  assign w_carry_out = (w_sum >= 5'd10);
  assign w_digit_res = w_carry_out ? (w_sum[3:0] - 4'd10) : w_sum[3:0];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    op_d       = op_q;
    pos_d      = pos_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    scan_cnt_d = scan_cnt_q;
    scan_idx_d = scan_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (add_req && !clr) begin
          if (operand <= c_bcd_max) begin
            op_d    = operand;
            pos_d   = op_pos;
            err_d   = 1'b0;
            idx_d   = 2'd0;
            carry_d = 1'b0;
            state_d = ST_ADD;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ST_ADD: begin
        acc_d[{idx_q, 2'b00} +: 4] = w_digit_res;
        carry_d = w_carry_out;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          ovf_d   = ovf_q | w_carry_out;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear aborts any addition in flight and overrides a same-cycle request.
    if (clr) begin
      acc_d   = 16'h0000;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
      idx_d   = 2'd0;
      carry_d = 1'b0;
      state_d = ST_IDLE;
    end

    if (scan_cnt_q >= c_scan_last) begin
      scan_cnt_d = 16'd0;
      scan_idx_d = scan_idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= 16'h0000;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      op_q       <= 4'd0;
      pos_q      <= 2'd0;
      idx_q      <= 2'd0;
      carry_q    <= 1'b0;
      scan_cnt_q <= 16'd0;
      scan_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      op_q       <= op_d;
      pos_q      <= pos_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign acc      = acc_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign ovf      = ovf_q;
  assign dig      = 4'b0001 << scan_idx_q;
  assign disp_hex = err_q ? c_err_hex : w_digits[scan_idx_q];

endmodule

`default_nettype wire

// File: doc/bcd_accum_scan_ctrl.md
BCD_ACCUM_SCAN_CTRL -- requirements
Module: bcd_accum_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd50000, meaning clock cycles each display digit is held active.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port add_req, input, 1, level-sampled request to add operand into the accumulator.
REQ-005 SHALL have port operand, input, 4, BCD digit to add; valid range 0-9.
REQ-006 SHALL have port op_pos, input, 2, accumulator digit position (0 = units) receiving the operand.
REQ-007 SHALL have port clr, input, 1, synchronous clear of the accumulator and flags.
REQ-008 SHALL have port acc, output, 16, 4-digit BCD accumulator, digit i at bits [4i+3:4i].
REQ-009 SHALL have port busy, output, 1, high while an addition is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, sticky invalid-operand flag.
REQ-012 SHALL have port ovf, output, 1, sticky carry-out-of-digit-3 flag.
REQ-013 SHALL have port dig, output, 4, one-hot active-high digit enable; dig[0] = rightmost digit.
REQ-014 SHALL have port disp_hex, output, 4, hex code for the active digit, feeding the existing hex-to-7-segment decoder.

Function
REQ-015 SHALL implement FSM IDLE -> ADD -> DONE -> IDLE.
REQ-016 IDLE: add_req=1 with operand<=9 and clr=0 SHALL latch operand and op_pos, clear err, and enter ADD with digit index 0.
REQ-017 IDLE: add_req=1 with operand>9 and clr=0 SHALL set err, leave acc unchanged, and stay in IDLE; busy and done stay 0.
REQ-018 ADD SHALL process one digit per cycle, indices 0..3 in order; the result sum = acc digit i + (i==op_pos ? operand : 0) + carry, with carry=0 at i=0.
REQ-019 Digit result SHALL be sum-10 with carry_out=1 if sum>=10, else sum with carry_out=0; sum is computed at 5 bits with no truncation.
REQ-020 After index 3 the FSM SHALL enter DONE; carry_out=1 at index 3 SHALL set ovf, and acc wraps modulo 10000.
REQ-021 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-022 Latency: for a request accepted in cycle N, busy=1 in cycles N+1..N+5, done=1 in cycle N+5, final acc valid from cycle N+5.
REQ-023 add_req while busy=1 SHALL be ignored, with no queueing.
REQ-024 clr=1 in any state SHALL, next cycle, set acc=0, err=0, ovf=0, state=IDLE, busy=0, done=0; clr wins over simultaneous add_req; an aborted add produces no done.
REQ-025 The scan counter SHALL count 0..SCAN_DIV-1; at terminal count it wraps to 0 and the scan index advances 0->1->2->3->0.
REQ-026 dig SHALL equal 4'b0001 shifted left by the scan index; the scan runs independently of FSM state.
REQ-027 disp_hex SHALL be acc digit[scan index], or 4'hE when err=1; it follows acc directly, so partial results during ADD are displayed.
REQ-028 SCAN_DIV=1 SHALL advance the scan index every cycle.

Reset
REQ-029 When rst_n=0 at a clock edge: acc=16'h0000, busy=0, done=0, err=0, ovf=0, FSM=IDLE, scan counter=0, scan index=0 (dig=4'b0001), disp_hex=4'h0.
REQ-030 A reset mid-ADD SHALL discard the operation with no done pulse; rst_n has priority over clr and add_req.

Verification
REQ-031 Reset; add 7 at pos0, then 5 at pos0 -> acc=16'h0012, done exactly at N+5 each, busy for 5 cycles each.
REQ-032 Add 9 at pos 0, 1, 2 and 3 (acc=16'h9999, ovf=0); then add 1 at pos0 -> acc=16'h0000, ovf=1, done at N+5.
REQ-033 From acc=16'h0012, add 4'hA -> err=1, acc unchanged, busy=0, disp_hex=4'hE on all digits; then add 3 at pos1 -> err=0, acc=16'h0042.
REQ-034 Pulse add_req again during busy -> ignored; acc reflects a single addition.
REQ-035 Assert clr in the 2nd ADD cycle -> next cycle acc=0, busy=0, ovf=0, and done never pulses.
REQ-036 SCAN_DIV=4, acc=16'h1234 -> dig cycles 0001/0010/0100/1000 with 4 cycles each; disp_hex shows 4,3,2,1 respectively.
